// File: rtl/dds_sequencer_if.sv
// Command, load-stream and RAM-side signal bundle for dds_sequencer.
// sweep_step is present only when DDS_SWEEP_EN is defined.
interface dds_sequencer_if #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int PHASE_W = 16
);
    logic [1:0]         cmd;
    logic               cmd_valid;
    logic               stop;
    logic [PHASE_W-1:0] tuning_word;
    logic [7:0]         burst_len;
`ifdef DDS_SWEEP_EN
    logic [PHASE_W-1:0] sweep_step;
`endif
    logic               s_valid;
    logic [DATA_W-1:0]  s_data;
    logic               s_ready;
    logic               ram_we;
    logic [ADDR_W-1:0]  ram_addr;
    logic [DATA_W-1:0]  ram_wdata;
    logic               out_valid;
    logic               full;
    logic               busy;
    logic               done;
    logic               cmd_err;

    modport master (
`ifdef DDS_SWEEP_EN
        output sweep_step,
`endif
        output cmd, cmd_valid, stop, tuning_word, burst_len, s_valid, s_data,
        input  s_ready, ram_we, ram_addr, ram_wdata, out_valid, full, busy, done, cmd_err
    );

    modport slave (
`ifdef DDS_SWEEP_EN
        input  sweep_step,
`endif
        input  cmd, cmd_valid, stop, tuning_word, burst_len, s_valid, s_data,
        output s_ready, ram_we, ram_addr, ram_wdata, out_valid, full, busy, done, cmd_err
    );
endinterface

// File: rtl/dds_sequencer.sv
// DDS waveform sequencer: loads the waveform RAM from a stream, then plays it back
// continuously or for burst_len periods. Define DDS_SWEEP_EN for a per-period tuning-word sweep.
module dds_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int PHASE_W = 16
) (
    input  logic           clk,
    input  logic           reset,
    dds_sequencer_if.slave bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_PLAY   = 2'd2;
    localparam logic [1:0] ST_BURST  = 2'd3;

    localparam logic [1:0] CMD_LOAD  = 2'b01;
    localparam logic [1:0] CMD_PLAY  = 2'b10;
    localparam logic [1:0] CMD_BURST = 2'b11;

    logic [1:0]         state;
    logic [ADDR_W-1:0]  wr_addr;
    logic [ADDR_W-1:0]  ram_addr_q;
    logic [DATA_W-1:0]  ram_wdata_q;
    logic               ram_we_q;
    logic               full_q;
    logic               done_q;
    logic               cmd_err_q;
    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] tw;
    logic [7:0]         burst_len_q;
    logic [7:0]         wrap_cnt;
`ifdef DDS_SWEEP_EN
    logic [PHASE_W-1:0] sweep_q;
`endif

    logic [PHASE_W-1:0] phase_nxt;
    logic [PHASE_W-1:0] tw_nxt;
    logic [8:0]         wrap_nxt;
    logic               carry;
    logic               carry_ahead;
    logic               burst_ok;

    // carry_ahead looks one step past phase_nxt so done can line up with the final output address
    always_comb begin
        phase_nxt = phase + tw;
        carry     = (phase > ~tw);
        tw_nxt    = tw;
`ifdef DDS_SWEEP_EN
        if (carry) begin
            tw_nxt = (tw > ~sweep_q) ? '1 : tw + sweep_q;
        end
`endif
        carry_ahead = (phase_nxt > ~tw_nxt);
        wrap_nxt    = {1'b0, wrap_cnt} + {8'd0, carry};
        burst_ok    = full_q && (bus.burst_len != 8'd0) && (bus.tuning_word != '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            wr_addr     <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            full_q      <= 1'b0;
            done_q      <= 1'b0;
            cmd_err_q   <= 1'b0;
            phase       <= '0;
            tw          <= '0;
            burst_len_q <= '0;
            wrap_cnt    <= '0;
`ifdef DDS_SWEEP_EN
            sweep_q     <= '0;
`endif
        end else begin
            ram_we_q  <= 1'b0;
            done_q    <= 1'b0;
            cmd_err_q <= 1'b0;
            if (bus.stop) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.cmd_valid) begin
                            case (bus.cmd)
                                CMD_LOAD: begin
                                    state   <= ST_LOAD;
                                    full_q  <= 1'b0;
                                    wr_addr <= '0;
                                end
                                CMD_PLAY, CMD_BURST: begin
                                    if ((bus.cmd == CMD_PLAY) ? full_q : burst_ok) begin
                                        state       <= (bus.cmd == CMD_PLAY) ? ST_PLAY : ST_BURST;
                                        phase       <= '0;
                                        tw          <= bus.tuning_word;
                                        ram_addr_q  <= '0;
                                        wrap_cnt    <= '0;
                                        burst_len_q <= bus.burst_len;
`ifdef DDS_SWEEP_EN
                                        sweep_q     <= bus.sweep_step;
`endif
                                    end else begin
                                        cmd_err_q <= 1'b1;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                    ST_LOAD: begin
                        if (bus.s_valid) begin
                            ram_we_q    <= 1'b1;
                            ram_addr_q  <= wr_addr;
                            ram_wdata_q <= bus.s_data;
                            wr_addr     <= wr_addr + 1'b1;
                            if (wr_addr == '1) begin
                                full_q <= 1'b1;
                                done_q <= 1'b1;
                                state  <= ST_IDLE;
                            end
                        end
                    end
                    default: begin
                        phase      <= phase_nxt;
                        tw         <= tw_nxt;
                        ram_addr_q <= phase_nxt[PHASE_W-1 -: ADDR_W];
                        if (state == ST_BURST) begin
                            wrap_cnt <= wrap_nxt[7:0];
                            if (carry && (wrap_nxt == {1'b0, burst_len_q})) begin
                                state <= ST_IDLE;
                            end else begin
                                done_q <= carry_ahead && ((wrap_nxt + 9'd1) == {1'b0, burst_len_q});
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign bus.s_ready   = (state == ST_LOAD);
    assign bus.out_valid = (state == ST_PLAY) || (state == ST_BURST);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.full      = full_q;
    assign bus.done      = done_q;
    assign bus.cmd_err   = cmd_err_q;
endmodule

// File: tb/tb_dds_sequencer.sv
// Bench for dds_sequencer: command-rejection and playback vector tables, load sequences,
// and a queue scoreboard fed by a reference phase-accumulator model.
module tb_dds_sequencer;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int PHASE_W = 16;

    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_LOAD  = 2'b01;
    localparam logic [1:0] CMD_PLAY  = 2'b10;
    localparam logic [1:0] CMD_BURST = 2'b11;

    typedef struct {
        logic [1:0]  cmd;
        logic [15:0] tw;
        logic [7:0]  bl;
        logic        exp_err;
    } err_vec_t;

    typedef struct {
        logic [1:0]  cmd;
        logic [15:0] tw;
        logic [7:0]  bl;
        int          cycles;
        logic [15:0] sweep;
    } play_vec_t;

    logic clk;
    logic reset;

    int total = 0;
    int bad   = 0;

    int we_count     = 0;
    int ov_count     = 0;
    int done_count   = 0;
    int done_last_we = 0;
    int done_ov_at   = -1;

    logic [15:0] wq[$];
    logic [7:0]  aq[$];

    err_vec_t  ev[5];
    play_vec_t pv[$];

    dds_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PHASE_W(PHASE_W)) bus ();

    dds_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PHASE_W(PHASE_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected to finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard: every write and every playback address is popped against the reference model
    always @(negedge clk) begin
        if (bus.ram_we) begin
            we_count++;
            if (wq.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL spurious_write: addr 0x%0h data 0x%0h, no write expected", bus.ram_addr, bus.ram_wdata);
            end else begin
                checkOutput("write", {bus.ram_addr, bus.ram_wdata}, {16'd0, wq.pop_front()});
            end
        end
        if (bus.out_valid) begin
            ov_count++;
            if (aq.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL spurious_out_valid: addr 0x%0h, no address expected", bus.ram_addr);
            end else begin
                checkOutput("play_addr", bus.ram_addr, {24'd0, aq.pop_front()});
            end
        end
        if (bus.done) begin
            done_count++;
            if (bus.out_valid) done_ov_at = ov_count;
            if (bus.ram_we && bus.ram_addr == 8'hFF) done_last_we++;
        end
    end

    task automatic applyStimulus(input logic [1:0] c, input logic [15:0] tw, input logic [7:0] bl);
        bus.cmd         = c;
        bus.tuning_word = tw;
        bus.burst_len   = bl;
        bus.cmd_valid   = 1'b1;
        @(negedge clk);
        bus.cmd_valid   = 1'b0;
        bus.cmd         = CMD_NOP;
    endtask

    // Independent phase-accumulator reference: one address per output cycle
    task automatic buildExpected(input play_vec_t v, output int n);
        logic [16:0] sum;
        logic [15:0] ph;
        logic [15:0] tw;
        int          wraps;
        ph    = 16'd0;
        tw    = v.tw;
        wraps = 0;
        n     = 0;
        for (int k = 0; k < 4096; k++) begin
            if (v.cmd == CMD_PLAY && n == v.cycles) break;
            aq.push_back(ph[15:8]);
            n++;
            sum = {1'b0, ph} + {1'b0, tw};
            ph  = sum[15:0];
            if (sum[16]) begin
                wraps++;
`ifdef DDS_SWEEP_EN
                tw = (({1'b0, tw} + {1'b0, v.sweep}) > 17'h0FFFF) ? 16'hFFFF : tw + v.sweep;
`endif
                if (v.cmd == CMD_BURST && wraps == int'(v.bl)) break;
            end
        end
    endtask

    task automatic runErrVectors(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            applyStimulus(ev[i].cmd, ev[i].tw, ev[i].bl);
            checkOutput($sformatf("err%0d_pulse", i), bus.cmd_err, ev[i].exp_err);
            checkOutput($sformatf("err%0d_busy", i), bus.busy, 0);
            checkOutput($sformatf("err%0d_out_valid", i), bus.out_valid, 0);
            @(negedge clk);
            checkOutput($sformatf("err%0d_pulse_end", i), bus.cmd_err, 0);
        end
    endtask

    task automatic loadRun(input int n_hs, input bit abort);
        int i;
        int we0;
        int d0;
        int dl0;
        we0 = we_count;
        d0  = done_count;
        dl0 = done_last_we;
        applyStimulus(CMD_LOAD, 16'd0, 8'd0);
        i = 0;
        for (int g = 0; g < n_hs * 2 + 10 && i < n_hs; g++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = i[7:0];
            if (bus.s_ready) begin
                wq.push_back({i[7:0], i[7:0]});
                i++;
            end
            @(negedge clk);
        end
        bus.s_data = 8'hA5;
        if (abort) begin
            bus.stop = 1'b1;
            @(negedge clk);
            bus.stop    = 1'b0;
            bus.s_valid = 1'b0;
        end else begin
            checkOutput("load_ready_drop", bus.s_ready, 0);
            @(negedge clk);
            bus.s_valid = 1'b0;
        end
        checkOutput("load_busy_end", bus.busy, 0);
        repeat (2) @(negedge clk);
        checkOutput("load_write_count", we_count - we0, n_hs);
        checkOutput("load_queue_empty", wq.size(), 0);
        checkOutput("load_done_count", done_count - d0, abort ? 0 : 1);
        checkOutput("load_full", bus.full, abort ? 0 : 1);
        checkOutput("load_s_ready", bus.s_ready, 0);
        if (!abort) checkOutput("load_done_with_last", done_last_we - dl0, 1);
    endtask

    task automatic runPlayback(input play_vec_t v);
        int n;
        int ov0;
        int d0;
        buildExpected(v, n);
        ov0        = ov_count;
        d0         = done_count;
        done_ov_at = -1;
`ifdef DDS_SWEEP_EN
        bus.sweep_step = v.sweep;
`endif
        applyStimulus(v.cmd, v.tw, v.bl);
        if (v.cmd == CMD_PLAY) begin
            repeat (v.cycles - 1) @(negedge clk);
            bus.stop = 1'b1;
            @(negedge clk);
            bus.stop = 1'b0;
            checkOutput("play_stop_out_valid", bus.out_valid, 0);
            checkOutput("play_no_done", done_count - d0, 0);
        end else begin
            for (int k = 0; k < 5000 && bus.busy; k++) @(negedge clk);
            checkOutput("burst_end_busy", bus.busy, 0);
            checkOutput("burst_done_count", done_count - d0, 1);
            checkOutput("burst_done_on_last", done_ov_at, ov0 + n);
        end
        @(negedge clk);
        checkOutput($sformatf("ov_cycles_tw%0h", v.tw), ov_count - ov0, n);
        checkOutput("addr_queue_empty", aq.size(), 0);
    endtask

    initial begin
        int        n;
        play_vec_t rv;

        bus.cmd         = CMD_NOP;
        bus.cmd_valid   = 1'b0;
        bus.stop        = 1'b0;
        bus.tuning_word = 16'd0;
        bus.burst_len   = 8'd0;
        bus.s_valid     = 1'b0;
        bus.s_data      = 8'd0;
`ifdef DDS_SWEEP_EN
        bus.sweep_step  = 16'd0;
`endif
        reset = 1'b0;

        ev[0] = '{CMD_PLAY,  16'h0300, 8'd0, 1'b1};
        ev[1] = '{CMD_BURST, 16'h0100, 8'd3, 1'b1};
        ev[2] = '{CMD_NOP,   16'h0100, 8'd3, 1'b0};
        ev[3] = '{CMD_BURST, 16'h0100, 8'd0, 1'b1};
        ev[4] = '{CMD_BURST, 16'h0000, 8'd3, 1'b1};

        pv.push_back(play_vec_t'{CMD_PLAY,  16'h0300, 8'd0, 20, 16'h0000});
        pv.push_back(play_vec_t'{CMD_PLAY,  16'h0155, 8'd0, 40, 16'h0000});
        pv.push_back(play_vec_t'{CMD_PLAY,  16'hFF00, 8'd0, 10, 16'h0000});
        pv.push_back(play_vec_t'{CMD_BURST, 16'h0100, 8'd3, 0,  16'h0000});
        pv.push_back(play_vec_t'{CMD_BURST, 16'h4000, 8'd2, 0,  16'h0000});
        pv.push_back(play_vec_t'{CMD_BURST, 16'h0155, 8'd2, 0,  16'h0000});
        pv.push_back(play_vec_t'{CMD_BURST, 16'hFFFF, 8'd1, 0,  16'h0000});
`ifdef DDS_SWEEP_EN
        pv.push_back(play_vec_t'{CMD_BURST, 16'h0100, 8'd2, 0,  16'h0100});
`endif

        repeat (3) @(negedge clk);
        checkOutput("reset_s_ready", bus.s_ready, 0);
        checkOutput("reset_ram_we", bus.ram_we, 0);
        checkOutput("reset_ram_addr", bus.ram_addr, 0);
        checkOutput("reset_full", bus.full, 0);
        checkOutput("reset_busy_ov", {bus.busy, bus.out_valid}, 0);
        checkOutput("reset_pulses", {bus.done, bus.cmd_err}, 0);
        reset = 1'b1;
        @(negedge clk);

        $display("[TB] command rejection with empty RAM");
        runErrVectors(0, 2);

        $display("[TB] aborted load, then full load");
        loadRun(100, 1'b1);
        loadRun(256, 1'b0);

        runErrVectors(3, 4);

        $display("[TB] playback vectors");
        foreach (pv[i]) runPlayback(pv[i]);

        bus.stop = 1'b1;
        applyStimulus(CMD_PLAY, 16'h0300, 8'd0);
        bus.stop = 1'b0;
        checkOutput("stop_cmd_err", bus.cmd_err, 0);
        checkOutput("stop_cmd_busy", bus.busy, 0);
        checkOutput("full_persists", bus.full, 1);

        $display("[TB] reset during playback");
        rv = '{CMD_PLAY, 16'h0300, 8'd0, 5, 16'h0000};
        buildExpected(rv, n);
        applyStimulus(rv.cmd, rv.tw, rv.bl);
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("midreset_out_valid", bus.out_valid, 0);
        checkOutput("midreset_busy", bus.busy, 0);
        checkOutput("midreset_full", bus.full, 0);
        checkOutput("midreset_ram_addr", bus.ram_addr, 0);
        @(negedge clk);
        checkOutput("midreset_queue_empty", aq.size(), 0);
        reset = 1'b1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dds_sequencer.md
# dds_sequencer

Sequencer for the DDS waveform path. It fills the waveform RAM from a sample stream, then plays it back by driving the RAM read address from a phase accumulator, either continuously or for a fixed number of periods. It sits between the host-side control logic and the waveform RAM/DAC path, and replaces ad-hoc write-enable and DDS-control sequencing with a single command interface.

## Interface
- ADDR_W, 8, waveform RAM address width (depth 2^ADDR_W)
- DATA_W, 8, sample width
- PHASE_W, 16, phase accumulator and tuning word width (PHASE_W ≥ ADDR_W)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cmd  in  2  command: 00 nop, 01 load, 10 play, 11 burst
- cmd_valid  in  1  cmd qualifier, sampled each rising edge
- stop  in  1  abort to IDLE, highest priority
- tuning_word  in  PHASE_W  phase increment, latched on play/burst accept
- burst_len  in  8  waveform periods per burst, latched on burst accept
- s_valid  in  1  load stream sample valid
- s_data  in  DATA_W  load stream sample
- s_ready  out  1  high only in LOAD
- ram_we  out  1  RAM write enable (registered)
- ram_addr  out  ADDR_W  RAM write/read address (registered)
- ram_wdata  out  DATA_W  RAM write data (registered)
- out_valid  out  1  high in PLAY/BURST; ram_addr is a valid read address
- full  out  1  RAM fully loaded
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse on LOAD or BURST completion
- cmd_err  out  1  one-cycle pulse on a rejected command

## Operation
- States: IDLE, LOAD, PLAY, BURST. Commands are accepted only in IDLE. In other states, cmd_valid is ignored without cmd_err.
- Acceptance rules in IDLE (cmd_valid=1):
  - load: always accepted. Clears full and wr_addr.
  - play: requires full=1.
  - burst: requires full=1, burst_len≠0 and tuning_word≠0.
  - Any failed condition → cmd_err pulse; state stays IDLE.
  - nop: no action.
- LOAD:
  - s_ready=1.
  - Each s_valid handshake writes s_data at wr_addr, then wr_addr increments.
  - After the write to address 2^ADDR_W−1: full←1, done pulse, → IDLE.
- PLAY:
  - On entry, phase←0 and tw←tuning_word.
  - Each cycle, phase←phase+tw, modulo 2^PHASE_W.
  - ram_addr = phase[PHASE_W−1 -: ADDR_W]; ram_we=0.
  - Runs until stop.
- BURST:
  - Same datapath as PLAY.
  - A wrap counter increments on each accumulator carry-out.
  - On the carry that brings the count to burst_len: done pulse, → IDLE. The address for that cycle is still output with out_valid=1.
- stop=1 from any state → IDLE on the next edge:
  - LOAD abort leaves full=0 and issues no further ram_we.
  - No done pulse.
  - stop in IDLE has no effect. stop with cmd_valid in the same cycle: stop wins, command dropped, no cmd_err.
- full persists through PLAY/BURST/stop. It is cleared only by load acceptance or reset.

## Timing
- Reset (reset=0): state IDLE. All outputs 0, including s_ready, ram_addr, full and done. Internal phase, tw and counters are 0.
- Command accepted at edge N → state/busy change visible after edge N; cmd_err/done are registered pulses of exactly one cycle.
- Load latency: handshake at edge N → ram_we=1 with ram_addr/ram_wdata for the cycle following edge N. Back-to-back handshakes give back-to-back writes.
- s_ready drops in the cycle after the final write handshake. A simultaneous s_valid in that cycle is not accepted.
- Playback: cycle after accept shows ram_addr=0, out_valid=1. The next cycle shows the top ADDR_W bits of tw, then 2·tw, and so on.
- BURST with tw=2^(PHASE_W−ADDR_W) and burst_len=L lasts exactly L·2^ADDR_W cycles of out_valid.
- Reset mid-operation: immediate return to reset values. full is lost.

## Configuration
- DDS_SWEEP_EN defined:
  - Adds input sweep_step [PHASE_W−1:0], latched on play/burst accept.
  - On every accumulator carry-out, tw←tw+sweep_step, saturating at 2^PHASE_W−1.
  - The new tw applies from the following cycle.
- DDS_SWEEP_EN undefined: the port is absent, and tw stays constant for the whole PLAY/BURST.

## Test plan
- Reset release, then play with full=0 → cmd_err pulse 1 cycle, state IDLE, out_valid=0.
- Load with 256 continuous samples s_data=i → ram_we for 256 consecutive cycles, addr 0..255, data=addr. Then full=1, one done pulse, s_ready=0.
- Load, stop asserted after 100 handshakes → IDLE next edge, full=0, exactly 100 writes, no done.
- After full load, play with tuning_word=0x0300 → ram_addr sequence 0,3,6,9,… Stop after 20 cycles → out_valid falls next edge.
- burst with tuning_word=0x0100, burst_len=3 → out_valid high exactly 768 cycles, addresses 0..255 three times, done pulses on the last cycle. burst_len=0 → cmd_err.
- With DDS_SWEEP_EN: burst with tuning_word=0x0100, sweep_step=0x0100, burst_len=2 → first period step 1 (256 cycles), second period step 2 (128 cycles), then done.
